// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle CHUNK-per-cycle adder; optional subtract via SERIAL_ADDER_SUB_EN
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]       slice;
  logic                 carry_into_msb;
  logic [WIDTH+CHUNK-1:0] s_shift;
  logic                 accept;
  logic [WIDTH-1:0]     b_load;
  logic                 carry_load;

  assign accept = (state_q == IDLE) && start_valid;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign slice = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_q};
  // Carry into a bit position is recoverable as a ^ b ^ sum at that position.
  assign carry_into_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];
  assign s_shift = {slice[CHUNK-1:0], s_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_shift[WIDTH+CHUNK-1:CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = slice[CHUNK];
          ovf_d   = carry_into_msb ^ slice[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign s            = s_q;
  assign cout         = cout_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0, start_ready, result_valid, result_ready = 1'b0;
  logic [15:0] a = '0, b = '0, s;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf;

  logic        sv2 = 1'b0, sr2, rv2, rr2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0, co2, ov2;
  logic [15:0] a2 = '0, b2 = '0, s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .result_valid(result_valid), .result_ready(result_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .result_valid(rv2), .result_ready(rr2),
    .s(s2), .cout(co2), .ovf(ov2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation on the CHUNK=4 instance, with optional backpressure and a rejected start pulse.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic ts, input int hold, input bit inject);
    logic [16:0] full;
    logic [15:0] be, es;
    logic        ci, ec, eo;
    int          lat;
    be = tb_;
    ci = tc;
    if (SUB_EN && ts) begin
      be = ~tb_;
      ci = 1'b1;
    end
    full = {1'b0, ta} + {1'b0, be} + {16'd0, ci};
    es = full[15:0];
    ec = full[16];
    eo = (ta[15] == be[15]) && (es[15] != ta[15]);

    lat = 0;
    while (!start_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("start_ready_idle", {31'd0, start_ready}, 32'd1);
    a = ta; b = tb_; cin = tc; sub = ts; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 50) begin
      if (inject && lat == 1) begin
        start_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA;
        chk("start_ready_run", {31'd0, start_ready}, 32'd0);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_valid = 1'b0;
    end
    chk("latency", lat, 32'd4);
    chk("s", {16'd0, s}, {16'd0, es});
    chk("cout", {31'd0, cout}, {31'd0, ec});
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, result_valid}, 32'd1);
      chk("hold_s", {15'd0, cout, s}, {15'd0, ec, es});
      chk("hold_ovf_ready", {30'd0, ovf, start_ready}, {30'd0, eo, 1'b0});
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_drop", {31'd0, result_valid}, 32'd0);
    chk("s_kept", {14'd0, ovf, cout, s}, {14'd0, eo, ec, es});
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_outs", {14'd0, result_valid, cout, ovf, s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    // Abort an operation mid-RUN with an asynchronous reset.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {15'd0, result_valid, s}, 32'd0);
    chk("abort_flags", {30'd0, cout, ovf}, 32'd0);
    chk("abort_ready", {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {30'd0, result_valid, start_ready}, 32'd1);
    end

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3, 1'b1);
    if (SUB_EN) begin
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), SUB_EN ? 1'($urandom) : 1'b0,
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    // CHUNK=WIDTH instance: single RUN cycle, then backpressure.
    @(negedge clk);
    a2 = 16'hFFFF; b2 = 16'h0001; cin2 = 1'b0; sub2 = 1'b0; sv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv2 = 1'b0;
    chk("w_run_state", {30'd0, rv2, sr2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w_latency1", {31'd0, rv2}, 32'd1);
    chk("w_result", {14'd0, ov2, co2, s2}, {14'd0, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w_hold", {13'd0, rv2, sr2, co2, s2}, {13'd0, 1'b1, 1'b0, 1'b1, 16'h0000});
    end
    rr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr2 = 1'b0;
    chk("w_release", {30'd0, rv2, sr2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
